// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed M x N learning layer: one shared MAC/update datapath steps neuron-by-neuron
// through forward and learn phases. Define NEURON_ACT_MINMAX_EN to add activation max/min tracking.
module neuron_learn_layer_seq #(
  parameter int unsigned N        = 16,
  parameter int unsigned M        = 56,
  parameter int unsigned ZW       = 8,
  parameter int unsigned WW       = 16,
  parameter int unsigned WFRAC    = 12,
  parameter int unsigned LR_SHIFT = 2,
  parameter int          INIT_W   = 4096,
  localparam int unsigned MW = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 learn,
  input  logic [N*ZW-1:0]      in,
  input  logic [M*ZW-1:0]      expected_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M*ZW-1:0]      out,
  output logic [N*ZW-1:0]      expected_in,
  output logic                 busy,
  input  logic [MW-1:0]        rd_m,
  input  logic [NW-1:0]        rd_n,
  output logic signed [WW-1:0] rd_w
`ifdef NEURON_ACT_MINMAX_EN
  ,
  output logic [M*WW-1:0]      act_max,
  output logic [M*WW-1:0]      act_min
`endif
);

  localparam int unsigned PW  = WW + ZW + 1;
  localparam int unsigned AW  = PW + NW + 1;
  localparam int unsigned EW  = ZW + 1;
  localparam int unsigned DW  = EW + ZW + 1;
  localparam int unsigned UW  = WW + DW + 1;
  localparam int unsigned EIW = ZW + MW + 1;
  localparam int unsigned SH  = 2*ZW - WFRAC + LR_SHIFT;
  localparam int WMAX = (2 ** (WW-1)) - 1;
  localparam int WMIN = -(2 ** (WW-1));
  localparam int ZMAX = (2 ** ZW) - 1;

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [WW-1:0] w_q [M][N];
  logic [N*ZW-1:0]      in_q;
  logic [M*ZW-1:0]      exp_q;
  logic                 learn_q;
  logic [MW-1:0]        m_q;
  logic [NW-1:0]        n_q;
  logic signed [AW-1:0] acc_q;
  logic [ZW-1:0]        out_q [M];
  logic [EIW-1:0]       ein_q [N];
  logic [ZW-1:0]        ein_avg_q [N];

  logic [ZW-1:0]        in_a [N];
  logic [ZW-1:0]        exp_a [M];
  logic                 last_n, last_mn;
  logic signed [WW-1:0] w_cur, w_new;
  logic signed [ZW:0]   x_s;
  logic signed [AW-1:0] acc_sum, act, ein_t;
  logic [ZW-1:0]        act_z, ein_z;
  logic signed [EW-1:0] err;
  logic signed [DW-1:0] delta;
  logic signed [UW-1:0] w_sum;

  function automatic logic [ZW-1:0] clamp_z(input logic signed [AW-1:0] v);
    if (v[AW-1]) return '0;
    if (v > AW'(ZMAX)) return '1;
    return ZW'(v);
  endfunction

  // Unpack captured vectors and pack registered results onto the flat ports
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_a[i]                 = in_q[i*ZW +: ZW];
      expected_in[i*ZW +: ZW] = ein_avg_q[i];
    end
    for (int j = 0; j < M; j++) begin
      exp_a[j]        = exp_q[j*ZW +: ZW];
      out[j*ZW +: ZW] = out_q[j];
    end
  end

  assign rd_w = w_q[rd_m][rd_n];

  // Shared datapath for the current (m,n) step
  always_comb begin
    last_n  = (n_q == NW'(N-1));
    last_mn = last_n && (m_q == MW'(M-1));
    w_cur   = w_q[m_q][n_q];
    x_s     = {1'b0, in_a[n_q]};
    acc_sum = acc_q + AW'(w_cur) * AW'(x_s);
    act     = acc_sum >>> WFRAC;
    act_z   = clamp_z(act);
    err     = $signed({1'b0, exp_a[m_q]}) - $signed({1'b0, out_q[m_q]});
    delta   = (DW'(err) * DW'(x_s)) >>> SH;
    w_sum   = UW'(w_cur) + UW'(delta);
    if (w_sum > UW'(WMAX))      w_new = WW'(WMAX);
    else if (w_sum < UW'(WMIN)) w_new = WW'(WMIN);
    else                        w_new = WW'(w_sum);
    ein_t   = ((AW'(err) * AW'(w_cur)) >>> WFRAC) + AW'(x_s);
    ein_z   = clamp_z(ein_t);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = FWD;
      FWD:     if (last_mn) state_d = learn_q ? BWD : DONE;
      BWD:     if (last_mn) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_q      <= '0;
      exp_q     <= '0;
      learn_q   <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      for (int j = 0; j < M; j++) out_q[j] <= '0;
      for (int i = 0; i < N; i++) begin
        ein_q[i]     <= '0;
        ein_avg_q[i] <= '0;
      end
      for (int j = 0; j < M; j++)
        for (int i = 0; i < N; i++) w_q[j][i] <= WW'(INIT_W);
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_q    <= in;
          exp_q   <= expected_out;
          learn_q <= learn;
          m_q     <= '0;
          n_q     <= '0;
          acc_q   <= '0;
          for (int i = 0; i < N; i++) ein_q[i] <= '0;
        end
        FWD, BWD: begin
          n_q <= last_n ? '0 : n_q + NW'(1);
          if (last_n) m_q <= last_mn ? '0 : m_q + MW'(1);
          if (state_q == FWD) begin
            if (last_n) begin
              out_q[m_q] <= act_z;
              acc_q      <= '0;
            end else begin
              acc_q <= acc_sum;
            end
          end else begin
            w_q[m_q][n_q] <= w_new;
            ein_q[n_q]    <= ein_q[n_q] + EIW'(ein_z);
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; hold until the consumer takes it
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (learn_q)
              for (int i = 0; i < N; i++) ein_avg_q[i] <= ZW'(ein_q[i] / EIW'(M));
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NEURON_ACT_MINMAX_EN
  logic signed [WW-1:0] act_sat;
  logic signed [WW-1:0] amax_q [M];
  logic signed [WW-1:0] amin_q [M];

  always_comb begin
    if (act > AW'(WMAX))      act_sat = WW'(WMAX);
    else if (act < AW'(WMIN)) act_sat = WW'(WMIN);
    else                      act_sat = WW'(act);
    for (int j = 0; j < M; j++) begin
      act_max[j*WW +: WW] = amax_q[j];
      act_min[j*WW +: WW] = amin_q[j];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < M; j++) begin
        amax_q[j] <= WW'(WMIN);
        amin_q[j] <= WW'(WMAX);
      end
    end else if (state_q == FWD && last_n) begin
      if (act_sat > amax_q[m_q]) amax_q[m_q] <= act_sat;
      if (act_sat < amin_q[m_q]) amin_q[m_q] <= act_sat;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Bench for neuron_learn_layer_seq: directed cases plus randomized transactions checked
// against an arithmetic reference model of the layer.
`timescale 1ns/1ps
module tb_neuron_learn_layer_seq;
  localparam int N = 2, M = 2, ZW = 8, WW = 16, WFRAC = 12, LR_SHIFT = 2, INIT_W = 4096;
  localparam int SH = 2*ZW - WFRAC + LR_SHIFT;
  localparam int ZMAX = 255, WMAX = 32767, WMIN = -32768;

  logic                 clock = 1'b0;
  logic                 reset, in_valid, in_ready, learn, out_valid, out_ready, busy;
  logic [N*ZW-1:0]      in_bus, expected_in;
  logic [M*ZW-1:0]      exp_bus, out;
  logic [0:0]           rd_m, rd_n;
  logic signed [WW-1:0] rd_w;
`ifdef NEURON_ACT_MINMAX_EN
  logic [M*WW-1:0]      act_max, act_min;
`endif

  int n_checks = 0, n_fail = 0;
  int mw [M][N];
  int mout [M];
  int mein [N];
  int cur_in [N];
  int cur_exp [M];

  always #5 clock = ~clock;

  neuron_learn_layer_seq #(.N(N), .M(M), .ZW(ZW), .WW(WW), .WFRAC(WFRAC),
                           .LR_SHIFT(LR_SHIFT), .INIT_W(INIT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .learn(learn), .in(in_bus), .expected_out(exp_bus), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .expected_in(expected_in), .busy(busy),
    .rd_m(rd_m), .rd_n(rd_n), .rd_w(rd_w)
`ifdef NEURON_ACT_MINMAX_EN
    , .act_max(act_max), .act_min(act_min)
`endif
  );

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int clampz(input int v);
    return (v < 0) ? 0 : ((v > ZMAX) ? ZMAX : v);
  endfunction

  function automatic int clampw(input int v);
    return (v < WMIN) ? WMIN : ((v > WMAX) ? WMAX : v);
  endfunction

  function automatic int out_m(input int m);
    logic [M*ZW-1:0] t;
    t = out;
    return int'(t[m*ZW +: ZW]);
  endfunction

  function automatic int ein_n(input int n);
    logic [N*ZW-1:0] t;
    t = expected_in;
    return int'(t[n*ZW +: ZW]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      mout[m] = 0;
      for (int n = 0; n < N; n++) mw[m][n] = INIT_W;
    end
    for (int n = 0; n < N; n++) mein[n] = 0;
  endtask

  // One transaction as the layer equations define it
  task automatic model_txn(input bit lrn);
    int acc, err, wold;
    int sum [N];
    for (int m = 0; m < M; m++) begin
      acc = 0;
      for (int n = 0; n < N; n++) acc += mw[m][n] * cur_in[n];
      mout[m] = clampz(acc >>> WFRAC);
    end
    if (lrn) begin
      for (int n = 0; n < N; n++) sum[n] = 0;
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          err  = cur_exp[m] - mout[m];
          wold = mw[m][n];
          mw[m][n] = clampw(wold + ((err * cur_in[n]) >>> SH));
          sum[n] += clampz(cur_in[n] + ((err * wold) >>> WFRAC));
        end
      for (int n = 0; n < N; n++) mein[n] = sum[n] / M;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic check_rd(input int m, input int n, input int want, input string tag);
    rd_m = 1'(m);
    rd_n = 1'(n);
    #1 check(tag, rd_w, want);
  endtask

  task automatic check_weights();
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) check_rd(m, n, mw[m][n], "rd_w");
  endtask

  task automatic check_results();
    for (int m = 0; m < M; m++) check("out", out_m(m), mout[m]);
    for (int n = 0; n < N; n++) check("expected_in", ein_n(n), mein[n]);
  endtask

  // Drive one request, measure latency, optionally stall in DONE, then handshake
  task automatic run_txn(input bit lrn, input int hold);
    int lat;
    for (int n = 0; n < N; n++) in_bus[n*ZW +: ZW] = ZW'(cur_in[n]);
    for (int m = 0; m < M; m++) exp_bus[m*ZW +: ZW] = ZW'(cur_exp[m]);
    learn = lrn;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    model_txn(lrn);
    lat = 0;
    while (!out_valid && lat < 4*M*N + 8) begin
      @(posedge clock);
      #1 lat++;
    end
    check("latency", lat, lrn ? 2*M*N + 1 : M*N + 1);
    check("busy_done", busy, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_bus   = (N*ZW)'($urandom);
      learn    = 1'($urandom);
      @(posedge clock);
      #1 check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out0", out_m(0), mout[0]);
    end
    in_valid = 1'b0;
    check_results();
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("hs_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  initial begin
    int prev [M];
    reset = 1'b1; in_valid = 1'b0; learn = 1'b0; out_ready = 1'b0;
    in_bus = '0; exp_bus = '0; rd_m = '0; rd_n = '0;
    do_reset();

    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_expected_in", expected_in, 0);
    check_weights();

    // Forward only
    cur_in = '{128, 64}; cur_exp = '{0, 0};
    run_txn(1'b0, 0);
    check("fwd_out0", out_m(0), 192);
    check("fwd_out1", out_m(1), 192);
    check_rd(0, 0, 4096, "fwd_w00");
    check_weights();

    // Learn step with known numbers
    cur_exp = '{255, 192};
    run_txn(1'b1, 0);
    check("lrn_out0", out_m(0), 192);
    check_rd(0, 0, 4222, "lrn_w00");
    check_rd(0, 1, 4159, "lrn_w01");
    check_rd(1, 0, 4096, "lrn_w10");
    check_rd(1, 1, 4096, "lrn_w11");
    check("lrn_ein0", ein_n(0), 159);
    check("lrn_ein1", ein_n(1), 95);
    check_weights();

    // Backpressure in DONE with a competing request
    cur_in = '{100, 200};
    run_txn(1'b0, 10);
    check("bp_ein_kept", ein_n(0), 159);
    @(posedge clock);
    #1 check("bp_no_accept", busy, 0);

    // Saturation then driving outputs down
    do_reset();
    cur_in = '{255, 255}; cur_exp = '{0, 0};
    run_txn(1'b0, 0);
    check("sat_out0", out_m(0), 255);
    check("sat_out1", out_m(1), 255);
    for (int m = 0; m < M; m++) prev[m] = out_m(m);
    for (int k = 0; k < 5; k++) begin
      run_txn(1'b1, 0);
      for (int m = 0; m < M; m++) begin
        check("sat_monotonic", (out_m(m) <= prev[m]) ? 1 : 0, 1);
        prev[m] = out_m(m);
      end
    end
    check_weights();

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      for (int n = 0; n < N; n++) cur_in[n] = int'($urandom_range(0, 255));
      for (int m = 0; m < M; m++) cur_exp[m] = int'($urandom_range(0, 255));
      run_txn(1'($urandom), int'($urandom_range(0, 3)));
      check_weights();
    end

    // Reset during the learn phase
    cur_in = '{200, 30}; cur_exp = '{10, 250};
    for (int n = 0; n < N; n++) in_bus[n*ZW +: ZW] = ZW'(cur_in[n]);
    for (int m = 0; m < M; m++) exp_bus[m*ZW +: ZW] = ZW'(cur_exp[m]);
    learn = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out", out, 0);
    check("abort_in_ready", in_ready, 1);
    check_weights();

    // Recovery after abort
    cur_in = '{128, 64}; cur_exp = '{255, 192};
    run_txn(1'b1, 1);
    check_weights();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_learn_layer_seq.md
Name: neuron_learn_layer_seq

Overview:
- Time-multiplexed, fully parametrised learning layer: M neurons over N inputs share one MAC/update datapath, stepping neuron-by-neuron and input-by-input under an FSM.
- Replaces the fixed-width flat instance array with weight storage, valid/ready handshakes, forward and learn phases, and an averaged back-propagated expected_in.
- Sits between adjacent layers in the training chain.

Parameters:
- N, 16: inputs per neuron.
- M, 56: neurons in the layer.
- ZW, 8: zero2one width; unsigned fraction, raw/2^ZW.
- WW, 16: signed weight width.
- WFRAC, 12: weight fraction bits.
- LR_SHIFT, 2: learning-rate right shift.
- INIT_W, 4096: reset value of every weight (1.0).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- learn  in  1  sampled with the request; 1 = run the BWD phase.
- in  in  N*ZW  input vector, element n at [n*ZW +: ZW].
- expected_out  in  M*ZW  targets, captured with the request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  M*ZW  neuron outputs.
- expected_in  out  N*ZW  averaged expected inputs; valid with out_valid when learn=1.
- busy  out  1  FSM is not in IDLE.
- rd_m  in  clog2(M)  debug weight-read neuron index.
- rd_n  in  clog2(N)  debug weight-read input index.
- rd_w  out  WW  w[rd_m][rd_n], combinational read.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - Every weight is set to INIT_W.
  - out, expected_in, accumulators and out_valid are cleared to 0; busy=0; in_ready=1 the cycle after reset.
  - Reset mid-operation aborts the transaction; there is no partial result.
- FSM: IDLE -> FWD -> (BWD if learn) -> DONE -> IDLE.
  - IDLE: on in_valid&&in_ready, capture in, expected_out and learn, then go to FWD.
  - FWD: exactly M*N cycles, index (m,n) in row-major order with n fastest.
    - Each cycle: acc += w[m][n]*in[n], signed, full width, no overflow.
    - On n=N-1, out[m] = clamp(acc >>> WFRAC, 0, 2^ZW-1) is registered and acc is cleared.
  - BWD: exactly M*N cycles, same order.
    - err = expected_out[m] - out[m], signed ZW+1 bits.
    - delta = (err*in[n]) >>> (2*ZW - WFRAC + LR_SHIFT), arithmetic shift.
    - w[m][n] saturates to the signed WW-bit range after adding delta.
    - ein[n] += clamp(in[n] + ((err*w_old) >>> WFRAC), 0, 2^ZW-1), where w_old is the pre-update weight.
    - After the last cycle, expected_in[n] = ein[n] / M, truncating division.
  - DONE: out_valid=1. Hold out and expected_in stable until out_ready; leave on out_valid&&out_ready.
- With learn=0: BWD is skipped, weights are unchanged, and expected_in keeps its previous value.
- Latency, counting the accept edge as cycle 0:
  - out_valid rises at cycle M*N+1 when learn=0.
  - out_valid rises at cycle 2*M*N+1 when learn=1.
- A new request can be accepted in the cycle after the DONE handshake.
- in_valid outside IDLE is ignored.
- Weights persist across transactions.
- rd_w reflects writes from the next cycle.

Optional Feature:
- Macro: NEURON_ACT_MINMAX_EN.
- Defined:
  - Adds output ports act_max and act_min, each M*WW bits.
  - Per neuron, records the max/min of the pre-clamp activation, saturated to WW bits, at each out[m] update.
  - Reset value: act_max = most-negative WW value, act_min = most-positive WW value.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Forward, N=2, M=2, defaults: in={128,64}, learn=0 -> out={192,192}, out_valid at cycle 5, weights stay 4096.
- Learn: same in, expected_out={255,192}, learn=1, out_ready=1.
  - out={192,192} and out_valid at cycle 9.
  - w[0]={4222,4159}, w[1]={4096,4096}.
  - expected_in={159,95}.
- Saturation: in={255,255}, weights 4096 -> out={255,255}. Repeated learn with expected_out={0,0} -> out decreases monotonically and never goes below 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out stable, in_ready=0; a second in_valid is not accepted until the handshake.
- Reset mid-BWD: assert reset at cycle 6 of a learn transaction -> next cycle busy=0 and out_valid=0, all rd_w=4096, out=0.
- NEURON_ACT_MINMAX_EN: forward {128,64} then {255,255} -> act_max[0]=510, act_min[0]=192.
